// File: rtl/dp_jtag_master.sv
// dp_jtag_master: host-side JTAG master. Converts scan commands (TAP reset,
// IR scan, DR scan, run-test-idle cycles) into tck/tms/tdi/trst waveforms
// derived from the system clock and returns the captured tdo bits.
// Every command starts and ends with the TAP in Run-Test-Idle.

module dp_jtag_master #(
    parameter int unsigned TCK_DIV = 4,
    parameter int unsigned MAX_LEN = 64,
    parameter int unsigned IR_LEN  = 5,
    parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_type,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               tck,
    output logic               tms,
    output logic               tdi,
    output logic               trst,
    input  logic               tdo
);

    localparam int unsigned    DIV_W    = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TCK_DIV - 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] LEN_IR   = LEN_W'(IR_LEN);
    localparam logic [LEN_W-1:0] LEN_ZERO = LEN_W'(0);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

    // tms path patterns ahead of the shift, bit 0 goes out first
    localparam logic [4:0] PRE_IR   = 5'b00011;  // SDS,SIS,CI,SI
    localparam logic [4:0] PRE_DR   = 5'b00001;  // SDS,CD,SD
    localparam logic [4:0] PRE_DR0  = 5'b01101;  // SDS,CD,E1D,UD,RTI

    typedef enum logic [1:0] {
        CMD_TAP_RESET = 2'd0,
        CMD_IR_SCAN   = 2'd1,
        CMD_DR_SCAN   = 2'd2,
        CMD_IDLE_CYC  = 2'd3
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_TLR   = 3'd1,
        ST_PRE   = 3'd2,
        ST_SHIFT = 3'd3,
        ST_POST  = 3'd4,
        ST_RESP  = 3'd5
    } state_e;

    state_e             state;
    cmd_e               op;
    logic               auto_rst;
    logic [LEN_W-1:0]   len;
    logic [LEN_W-1:0]   bit_cnt;     // tck bits left in the current segment after this one
    logic [DIV_W-1:0]   div_cnt;
    logic [4:0]         pre_sr;
    logic [MAX_LEN-1:0] dat_sr;
    logic [MAX_LEN-1:0] cap;
    logic [MAX_LEN-1:0] cap_mask;

    logic               active_c;
    logic               half_done_c;
    logic               scan_c;
    logic               dr_zero_c;
    logic               cmd_done_c;
    logic [LEN_W-1:0]   dr_len_c;

    // Segment bookkeeping: phase end, command completion and DR length clamp
    always_comb begin
        active_c    = (state == ST_TLR) || (state == ST_PRE) ||
                      (state == ST_SHIFT) || (state == ST_POST);
        half_done_c = (div_cnt == DIV_LAST);
        scan_c      = (op == CMD_IR_SCAN) || (op == CMD_DR_SCAN);
        dr_zero_c   = (op == CMD_DR_SCAN) && (len == LEN_ZERO);
        dr_len_c    = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
        cmd_done_c  = 1'b0;
        if (active_c && half_done_c && tck && (bit_cnt == LEN_ZERO)) begin
            cmd_done_c = (state == ST_TLR) || (state == ST_POST) ||
                         ((state == ST_PRE) && dr_zero_c) ||
                         ((state == ST_SHIFT) && (op == CMD_IDLE_CYC));
        end
    end

    // Command FSM, tck generator and tdo capture
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_TLR;
            op        <= CMD_TAP_RESET;
            auto_rst  <= 1'b1;
            len       <= LEN_ZERO;
            bit_cnt   <= LEN_W'(5);
            div_cnt   <= '0;
            pre_sr    <= '0;
            dat_sr    <= '0;
            cap       <= '0;
            cap_mask  <= '0;
            tck       <= 1'b0;
            tms       <= 1'b1;
            tdi       <= 1'b0;
            trst      <= 1'b0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (cmd_done_c) begin
                // last high phase over: TAP is in RTI, hand back control
                state     <= ST_IDLE;
                tck       <= 1'b0;
                tdi       <= 1'b0;
                trst      <= 1'b1;
                div_cnt   <= '0;
                cmd_ready <= 1'b1;
                auto_rst  <= 1'b0;
                if (!auto_rst) begin
                    rsp_valid <= 1'b1;
                    rsp_data  <= cap;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (cmd_valid && cmd_ready) begin
                            cmd_ready <= 1'b0;
                            op        <= cmd_e'(cmd_type);
                            div_cnt   <= '0;
                            tck       <= 1'b0;
                            tdi       <= 1'b0;
                            cap       <= '0;
                            cap_mask  <= MAX_LEN'(1);
                            dat_sr    <= cmd_data;
                            case (cmd_e'(cmd_type))
                                CMD_TAP_RESET: begin
                                    state   <= ST_TLR;
                                    len     <= LEN_ZERO;
                                    bit_cnt <= LEN_W'(5);
                                    tms     <= 1'b1;
                                    trst    <= 1'b0;
                                end
                                CMD_IR_SCAN: begin
                                    state   <= ST_PRE;
                                    len     <= LEN_IR;
                                    pre_sr  <= PRE_IR;
                                    bit_cnt <= LEN_W'(3);
                                    tms     <= PRE_IR[0];
                                end
                                CMD_DR_SCAN: begin
                                    state <= ST_PRE;
                                    len   <= dr_len_c;
                                    tms   <= 1'b1;
                                    if (dr_len_c == LEN_ZERO) begin
                                        pre_sr  <= PRE_DR0;
                                        bit_cnt <= LEN_W'(4);
                                    end else begin
                                        pre_sr  <= PRE_DR;
                                        bit_cnt <= LEN_W'(2);
                                    end
                                end
                                default: begin
                                    len     <= cmd_len;
                                    bit_cnt <= cmd_len - LEN_ONE;
                                    tms     <= 1'b0;
                                    state   <= (cmd_len == LEN_ZERO) ? ST_RESP : ST_SHIFT;
                                end
                            endcase
                        end
                    end
                    ST_RESP: begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b1;
                        rsp_data  <= cap;
                        cmd_ready <= 1'b1;
                    end
                    default: begin
                        if (half_done_c) begin
                            div_cnt <= '0;
                            if (!tck) begin
                                // rising tck: capture tdo for scan shift bits
                                tck <= 1'b1;
                                if ((state == ST_SHIFT) && scan_c) begin
                                    if (tdo) begin
                                        cap <= cap | cap_mask;
                                    end
                                    cap_mask <= cap_mask << 1;
                                end
                            end else begin
                                // falling tck: start the low phase of the next bit
                                tck <= 1'b0;
                                case (state)
                                    ST_TLR: begin
                                        bit_cnt <= bit_cnt - LEN_ONE;
                                        tms     <= (bit_cnt != LEN_ONE);
                                    end
                                    ST_PRE: begin
                                        if (bit_cnt == LEN_ZERO) begin
                                            state   <= ST_SHIFT;
                                            bit_cnt <= len - LEN_ONE;
                                            tms     <= (len == LEN_ONE);
                                            tdi     <= dat_sr[0];
                                            dat_sr  <= dat_sr >> 1;
                                        end else begin
                                            bit_cnt <= bit_cnt - LEN_ONE;
                                            tms     <= pre_sr[1];
                                            pre_sr  <= pre_sr >> 1;
                                        end
                                    end
                                    ST_SHIFT: begin
                                        if (bit_cnt == LEN_ZERO) begin
                                            state   <= ST_POST;
                                            bit_cnt <= LEN_ONE;
                                            tms     <= 1'b1;
                                            tdi     <= 1'b0;
                                        end else begin
                                            bit_cnt <= bit_cnt - LEN_ONE;
                                            tms     <= scan_c && (bit_cnt == LEN_ONE);
                                            tdi     <= scan_c && dat_sr[0];
                                            dat_sr  <= dat_sr >> 1;
                                        end
                                    end
                                    ST_POST: begin
                                        bit_cnt <= LEN_ZERO;
                                        tms     <= 1'b0;
                                    end
                                    default: begin
                                        tms <= tms;
                                    end
                                endcase
                            end
                        end else begin
                            div_cnt <= div_cnt + DIV_W'(1);
                        end
                    end
                endcase
            end
        end
    end

endmodule
